pixel_controller: RTL and testbench

Time-multiplexed scan controller for the eight-digit seven-segment display. It divides the system clock into per-digit refresh slots and produces the 3-bit digit select consumed by the downstream 8-to-1 address/data nibble mux. It also drives the matching active-low anode enables, with a programmable blanking interval at the start of each slot so the mux output and segment decode settle before the digit lights (anti-ghosting). Per-digit mask and global enable inputs allow digits to be suppressed without changing the scan timing.

---
 rtl/pixel_controller.sv | 63 ++++++
 tb/tb_pixel_controller.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pixel_controller.sv
// Eight-digit seven-segment scan controller: per-digit refresh slots, digit select,
// and active-low anode enables with a blanking interval at the start of each slot.
module pixel_controller #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned REFRESH_HZ   = 480,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [7:0] digit_mask,
    output logic [2:0] sel,
    output logic [7:0] a,
    output logic       frame_start
);

    localparam int unsigned DIV = CLK_HZ / REFRESH_HZ;
    localparam int unsigned CW  = $clog2(DIV);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    sel_next;
    logic [7:0]    a_next;
    logic          frame_start_next;

    // Anode decision uses the next-state slot position so a always matches the registered sel.
    always_comb begin
        cnt_next         = '0;
        sel_next         = sel;
        a_next           = '1;
        frame_start_next = 1'b0;
        if (en) begin
            if (cnt == CNT_LAST) begin
                cnt_next = '0;
                sel_next = sel + 3'd1;
            end else begin
                cnt_next = cnt + CW'(1);
            end
            if ((cnt_next >= CNT_BLANK) && digit_mask[sel_next]) begin
                a_next = ~(8'b1 << sel_next);
            end
            frame_start_next = (cnt == CNT_LAST) && (sel == 3'd7);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            sel         <= '0;
            a           <= '1;
            frame_start <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            sel         <= sel_next;
            a           <= a_next;
            frame_start <= frame_start_next;
        end
    end

endmodule

// File: tb/tb_pixel_controller.sv
// Directed bench for pixel_controller with DIV=10 and two blanking cycles per slot.
module tb_pixel_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] digit_mask = 8'hFF;
    logic [2:0] sel;
    logic [7:0] a;
    logic       frame_start;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pixel_controller #(
        .CLK_HZ(1000),
        .REFRESH_HZ(100),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .en(en),
        .digit_mask(digit_mask),
        .sel(sel),
        .a(a),
        .frame_start(frame_start)
    );

    function automatic logic [7:0] exp_a(input int cnt, input int s);
        logic [7:0] one;
        one = 8'b1;
        if (cnt >= 2 && digit_mask[s] == 1'b1) return ~(one << s);
        return 8'hFF;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_state(input string tag, input int cnt, input int s, input logic fs);
        check({tag, "/sel"}, {5'd0, sel}, 8'(s));
        check({tag, "/a"}, a, exp_a(cnt, s));
        check({tag, "/frame_start"}, {7'd0, frame_start}, {7'd0, fs});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // At most one anode low, and only the one matching sel.
    always @(negedge clk) begin
        vectors++;
        assert (($countones(~a) <= 1) && (a === 8'hFF || a === ~(8'b1 << sel))) else begin
            miscompares++;
            $error("FAIL invariant observed a=%h sel=%0d expected one-hot-low on sel or FF", a, sel);
        end
    end

    initial begin
        repeat (3) tick;
        check("reset/sel", {5'd0, sel}, 8'h00);
        check("reset/a", a, 8'hFF);
        check("reset/frame_start", {7'd0, frame_start}, 8'h00);

        reset_n = 1'b1;
        en = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            tick;
            check_state("scan", k % 10, (k / 10) % 8, (k % 80) == 0);
        end

        digit_mask = 8'b1010_1010;
        for (int k = 201; k <= 280; k++) begin
            tick;
            check_state("mask", k % 10, (k / 10) % 8, (k % 80) == 0);
        end

        digit_mask = 8'hFF;
        for (int k = 281; k <= 355; k++) begin
            tick;
            check_state("pre_gap", k % 10, (k / 10) % 8, (k % 80) == 0);
        end
        check("gap_entry/a", a, 8'hF7);

        en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick;
            check_state("gap_off", 0, 3, 1'b0);
        end

        en = 1'b1;
        for (int j = 1; j <= 25; j++) begin
            tick;
            check_state("gap_on", j % 10, 3 + j / 10, 1'b0);
        end
        check("slot5/a", a, 8'hDF);

        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst/sel", {5'd0, sel}, 8'h00);
        check("async_rst/a", a, 8'hFF);
        check("async_rst/frame_start", {7'd0, frame_start}, 8'h00);
        tick;
        tick;
        check("rst_hold/sel", {5'd0, sel}, 8'h00);
        check("rst_hold/a", a, 8'hFF);

        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick;
            check_state("restart", k % 10, (k / 10) % 8, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
